input_conditioner: RTL and testbench

Front-end stage for the 8-bit multiplier datapath, sitting directly upstream of the multiplier control FSM. It turns the raw active-low Run and ClearA_LoadB push-buttons into clean, debounced, active-high levels and single-cycle rising-edge pulses. It also synchronizes the eight operand switches into the clock domain. The control FSM consumes the `Run` and `ClearA_LoadB` levels directly, and the datapath loads `S` into register B.

---
 rtl/input_conditioner.sv | 61 ++++++
 tb/tb_input_conditioner.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/input_conditioner.sv
// input_conditioner: synchronizes and debounces the Run/ClearA_LoadB buttons into levels and press pulses, and synchronizes SW into S
module input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run_n,
  input  logic       ClearA_LoadB_n,
  input  logic [7:0] SW,
  output logic       Run,
  output logic       ClearA_LoadB,
  output logic       Run_pulse,
  output logic       ClearA_LoadB_pulse,
  output logic [7:0] S
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic [1:0] meta, sync_n, stable, pulse, primed;
  logic [7:0] sw_meta;
  // primed marks when the second button flop holds a value sampled after reset,
  // so a button held through reset is never mistaken for a release
  always_ff @(posedge Clk)
    if (Reset) begin
      meta    <= '1;
      sync_n  <= '1;
      primed  <= '0;
      sw_meta <= '0;
      S       <= '0;
    end else begin
      meta    <= {ClearA_LoadB_n, Run_n};
      sync_n  <= meta;
      primed  <= {primed[0], 1'b1};
      sw_meta <= SW;
      S       <= sw_meta;
    end
  for (genvar i = 0; i < 2; i++) begin : g_ch
    logic sync, stab, prev, armed, pls;
    logic [CW-1:0] cnt;
    assign sync = ~sync_n[i];
    always_ff @(posedge Clk)
      if (Reset) begin
        stab  <= 1'b0;
        prev  <= 1'b0;
        armed <= 1'b0;
        pls   <= 1'b0;
        cnt   <= '0;
      end else begin
        pls   <= stab & ~prev & armed;
        prev  <= stab;
        armed <= armed | (primed[1] & ~stab & ~sync);
        cnt   <= (sync == stab || cnt == LAST) ? '0 : cnt + CW'(1);
        if (sync != stab && cnt == LAST) stab <= sync;
      end
    assign stable[i] = stab;
    assign pulse[i]  = pls;
  end
  assign Run                = stable[0];
  assign ClearA_LoadB       = stable[1];
  assign Run_pulse          = pulse[0];
  assign ClearA_LoadB_pulse = pulse[1];
endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: directed and randomized checks of input_conditioner against an edge-history reference model
module tb_input_conditioner;
  localparam int D = 16;
  logic       Clk, Reset, Run_n, ClearA_LoadB_n;
  logic [7:0] SW, S;
  logic       Run, ClearA_LoadB, Run_pulse, ClearA_LoadB_pulse;
  int checks = 0, fails = 0;
  input_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
    .Clk(Clk), .Reset(Reset), .Run_n(Run_n), .ClearA_LoadB_n(ClearA_LoadB_n), .SW(SW),
    .Run(Run), .ClearA_LoadB(ClearA_LoadB), .Run_pulse(Run_pulse),
    .ClearA_LoadB_pulse(ClearA_LoadB_pulse), .S(S)
  );
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;
  // reference model: per-edge history of raw samples; a button is seen two edges
  // after sampling, and a level flips after D consecutive edges of disagreement
  int edge_n = 0, last_rst = -100;
  logic       hist [2][0:8191];
  logic [7:0] sw_hist [0:8191];
  logic [1:0] m_stable, m_prev, m_armed, m_pulse;
  int         m_run [2];
  logic [7:0] m_s;
  always @(posedge Clk) begin : model
    logic sy, rs;
    edge_n = edge_n + 1;
    if (Reset) begin
      last_rst = edge_n;
      m_stable = '0; m_prev = '0; m_armed = '0; m_pulse = '0; m_s = '0;
      m_run = '{0, 0};
    end else begin
      for (int c = 0; c < 2; c++) begin
        rs = (edge_n - 2 > last_rst);
        sy = rs ? hist[c][edge_n-2] : 1'b0;
        m_pulse[c] = m_stable[c] & ~m_prev[c] & m_armed[c];
        if (rs && !sy && !m_stable[c]) m_armed[c] = 1'b1;
        m_prev[c] = m_stable[c];
        if (sy != m_stable[c]) begin
          m_run[c] = m_run[c] + 1;
          if (m_run[c] == D) begin
            m_stable[c] = sy;
            m_run[c] = 0;
          end
        end else m_run[c] = 0;
      end
      m_s = (edge_n - 1 > last_rst) ? sw_hist[edge_n-1] : 8'h00;
    end
    hist[0][edge_n] = ~Run_n;
    hist[1][edge_n] = ~ClearA_LoadB_n;
    sw_hist[edge_n] = SW;
  end
  logic [11:0] obs, expv;
  assign obs  = {Run, ClearA_LoadB, Run_pulse, ClearA_LoadB_pulse, S};
  assign expv = {m_stable[0], m_stable[1], m_pulse[0], m_pulse[1], m_s};
  task automatic cyc;
    @(posedge Clk);
    #1;
  endtask
  task automatic test_reset;
    Reset = 1; Run_n = 1; ClearA_LoadB_n = 1; SW = 8'hFF;
    for (int k = 0; k < 3; k++) begin
      cyc();
      checks++; if (obs !== 12'h000) begin fails++; $display("FAIL reset_hold edge %0d got %h expected 000", edge_n, obs); end
    end
    Reset = 0;
    cyc();
    checks++; if (obs !== 12'h000) begin fails++; $display("FAIL reset_release edge %0d got %h expected 000", edge_n, obs); end
    for (int k = 0; k < 6; k++) begin
      cyc();
      checks++; if (obs !== expv) begin fails++; $display("FAIL model_reset edge %0d got %h expected %h", edge_n, obs, expv); end
    end
  endtask
  task automatic test_clean_press;
    int t0, t1, pulses;
    logic e_lvl, e_pls;
    t1 = 1 << 30; pulses = 0;
    t0 = edge_n + 1; Run_n = 0;
    for (int k = 0; k < 72; k++) begin
      if (k == 50) begin Run_n = 1; t1 = edge_n + 1; end
      cyc();
      e_lvl = (edge_n >= t0 + D + 1) && (edge_n < t1 + D + 1);
      e_pls = (edge_n == t0 + D + 2);
      pulses += int'(Run_pulse);
      checks++; if (Run !== e_lvl) begin fails++; $display("FAIL clean_level edge %0d got %b expected %b", edge_n - t0, Run, e_lvl); end
      checks++; if (Run_pulse !== e_pls) begin fails++; $display("FAIL clean_pulse edge %0d got %b expected %b", edge_n - t0, Run_pulse, e_pls); end
      checks++; if (obs !== expv) begin fails++; $display("FAIL model_clean edge %0d got %h expected %h", edge_n, obs, expv); end
    end
    checks++; if (pulses != 1) begin fails++; $display("FAIL clean_pulse_count got %0d expected 1", pulses); end
  endtask
  task automatic test_bounce;
    int tf, pulses;
    logic e_lvl, e_pls;
    tf = 1 << 30; pulses = 0;
    ClearA_LoadB_n = 0;
    for (int k = 0; k < 52; k++) begin
      if (k == 10) ClearA_LoadB_n = 1;
      if (k == 11) begin ClearA_LoadB_n = 0; tf = edge_n + 1; end
      cyc();
      e_lvl = (edge_n >= tf + D + 1);
      e_pls = (edge_n == tf + D + 2);
      pulses += int'(ClearA_LoadB_pulse);
      checks++; if (ClearA_LoadB !== e_lvl) begin fails++; $display("FAIL bounce_level k %0d got %b expected %b", k, ClearA_LoadB, e_lvl); end
      checks++; if (ClearA_LoadB_pulse !== e_pls) begin fails++; $display("FAIL bounce_pulse k %0d got %b expected %b", k, ClearA_LoadB_pulse, e_pls); end
      checks++; if (obs !== expv) begin fails++; $display("FAIL model_bounce edge %0d got %h expected %h", edge_n, obs, expv); end
    end
    checks++; if (pulses != 1) begin fails++; $display("FAIL bounce_pulse_count got %0d expected 1", pulses); end
    ClearA_LoadB_n = 1;
    for (int k = 0; k < 25; k++) begin
      cyc();
      checks++; if (obs !== expv) begin fails++; $display("FAIL model_bounce_rel edge %0d got %h expected %h", edge_n, obs, expv); end
    end
  endtask
  task automatic test_held_through_reset;
    int r, pulses;
    logic e_lvl;
    Run_n = 0; Reset = 1;
    repeat (4) cyc();
    r = edge_n; Reset = 0; pulses = 0;
    for (int k = 0; k < 25; k++) begin
      cyc();
      e_lvl = (edge_n >= r + D + 2);
      pulses += int'(Run_pulse);
      checks++; if (Run !== e_lvl) begin fails++; $display("FAIL held_level edge %0d got %b expected %b", edge_n - r, Run, e_lvl); end
      checks++; if (obs !== expv) begin fails++; $display("FAIL model_held edge %0d got %h expected %h", edge_n, obs, expv); end
    end
    checks++; if (pulses != 0) begin fails++; $display("FAIL held_no_pulse got %0d expected 0", pulses); end
    Run_n = 1;
    for (int k = 0; k < 25; k++) begin
      cyc();
      checks++; if (obs !== expv) begin fails++; $display("FAIL model_held_rel edge %0d got %h expected %h", edge_n, obs, expv); end
    end
    Run_n = 0; pulses = 0;
    for (int k = 0; k < 25; k++) begin
      cyc();
      pulses += int'(Run_pulse);
      checks++; if (obs !== expv) begin fails++; $display("FAIL model_held_repress edge %0d got %h expected %h", edge_n, obs, expv); end
    end
    checks++; if (pulses != 1) begin fails++; $display("FAIL held_repress_pulse got %0d expected 1", pulses); end
    Run_n = 1;
    repeat (25) cyc();
  endtask
  task automatic test_simultaneous;
    int t0, both;
    t0 = edge_n + 1; both = 0;
    Run_n = 0; ClearA_LoadB_n = 0;
    for (int k = 0; k < 25; k++) begin
      cyc();
      both += int'(Run_pulse & ClearA_LoadB_pulse);
      checks++; if ({Run, ClearA_LoadB} !== {2{edge_n >= t0 + D + 1}}) begin fails++; $display("FAIL simul_levels edge %0d got %b%b expected %b", edge_n - t0, Run, ClearA_LoadB, edge_n >= t0 + D + 1); end
      checks++; if ({Run_pulse, ClearA_LoadB_pulse} !== {2{edge_n == t0 + D + 2}}) begin fails++; $display("FAIL simul_pulses edge %0d got %b%b expected %b", edge_n - t0, Run_pulse, ClearA_LoadB_pulse, edge_n == t0 + D + 2); end
      checks++; if (obs !== expv) begin fails++; $display("FAIL model_simul edge %0d got %h expected %h", edge_n, obs, expv); end
    end
    checks++; if (both != 1) begin fails++; $display("FAIL simul_pulse_count got %0d expected 1", both); end
    Run_n = 1; ClearA_LoadB_n = 1;
    for (int k = 0; k < 25; k++) begin
      cyc();
      checks++; if (obs !== expv) begin fails++; $display("FAIL model_simul_rel edge %0d got %h expected %h", edge_n, obs, expv); end
    end
  endtask
  task automatic test_switch_and_midreset;
    int r, pulses;
    logic e_lvl;
    SW = 8'h00;
    repeat (3) cyc();
    SW = 8'hA5;
    cyc();
    checks++; if (S !== 8'h00) begin fails++; $display("FAIL sw_first_edge got %h expected 00", S); end
    cyc();
    checks++; if (S !== 8'hA5) begin fails++; $display("FAIL sw_second_edge got %h expected a5", S); end
    Run_n = 0;
    repeat (8) cyc();
    Reset = 1;
    repeat (2) cyc();
    r = edge_n; Reset = 0; pulses = 0;
    for (int k = 0; k < 25; k++) begin
      cyc();
      e_lvl = (edge_n >= r + D + 2);
      pulses += int'(Run_pulse);
      checks++; if (Run !== e_lvl) begin fails++; $display("FAIL midreset_level edge %0d got %b expected %b", edge_n - r, Run, e_lvl); end
      checks++; if (obs !== expv) begin fails++; $display("FAIL model_midreset edge %0d got %h expected %h", edge_n, obs, expv); end
    end
    checks++; if (pulses != 0) begin fails++; $display("FAIL midreset_no_pulse got %0d expected 0", pulses); end
    Run_n = 1;
    repeat (25) cyc();
  endtask
  task automatic test_random;
    int dur [2];
    int rst_left;
    dur = '{0, 0}; rst_left = 0;
    for (int k = 0; k < 1500; k++) begin
      for (int c = 0; c < 2; c++) begin
        if (dur[c] == 0) begin
          if (c == 0) Run_n = ~Run_n; else ClearA_LoadB_n = ~ClearA_LoadB_n;
          dur[c] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : $urandom_range(5, 40);
        end else dur[c]--;
      end
      if ($urandom_range(0, 40) == 0) SW = 8'($urandom);
      if (rst_left == 0 && $urandom_range(0, 300) == 0) rst_left = $urandom_range(1, 3);
      Reset = (rst_left != 0);
      if (rst_left != 0) rst_left--;
      cyc();
      checks++; if (obs !== expv) begin fails++; $display("FAIL model_random edge %0d got %h expected %h", edge_n, obs, expv); end
    end
    Reset = 0;
  endtask
  initial begin
    Reset = 1; Run_n = 1; ClearA_LoadB_n = 1; SW = 8'h00;
    test_reset();
    test_clean_press();
    test_bounce();
    test_held_through_reset();
    test_simultaneous();
    test_switch_and_midreset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
